// File: rtl/snoop_msi_array.sv
// MSI coherence controller for a direct-mapped cache: per-line state/tag, CPU and snoop handling.
// Optional WB_COUNT_EN adds a saturating writeback counter output wb_count.
module snoop_msi_array #(
  parameter  int LINES  = 4,
  parameter  int TAG_W  = 4,
  localparam int IDX_W  = $clog2(LINES),
  localparam int ADDR_W = TAG_W + IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        bus_acao,
  input  logic [ADDR_W-1:0] bus_addr,
  output logic              cpu_hit,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic [1:0]        bus_req_acao,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              writeback,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              abort
`ifdef WB_COUNT_EN
  ,
  output logic [15:0]       wb_count
`endif
);

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_S = 2'b01,
    ST_M = 2'b10
  } st_e;

  localparam logic [1:0] ACT_RD   = 2'b00;
  localparam logic [1:0] ACT_INV  = 2'b01;
  localparam logic [1:0] ACT_WR   = 2'b10;
  localparam logic [1:0] ACT_NULL = 2'b11;

  st_e              st_q   [LINES];
  st_e              st_d   [LINES];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [TAG_W-1:0] tag_d  [LINES];

  logic              hit_q, hit_d;
  logic              req_q, req_d;
  logic [1:0]        racao_q, racao_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              wb_q, wb_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              abort_q, abort_d;

  logic [IDX_W-1:0] s_idx, c_idx;
  logic [TAG_W-1:0] s_tag, c_tag;
  logic             s_match, c_match;
  logic             snoop;

  function automatic logic is_valid(input st_e s);
    return (s == ST_S) || (s == ST_M);
  endfunction

  assign s_idx = bus_addr[IDX_W-1:0];
  assign s_tag = bus_addr[ADDR_W-1:IDX_W];
  assign c_idx = cpu_addr[IDX_W-1:0];
  assign c_tag = cpu_addr[ADDR_W-1:IDX_W];

  assign s_match = is_valid(st_q[s_idx]) &&
                   (tag_q[s_idx] == s_tag);
  assign c_match = is_valid(st_q[c_idx]) &&
                   (tag_q[c_idx] == c_tag);

  assign snoop     = (bus_acao != ACT_NULL);
  assign cpu_stall = cpu_valid & snoop;

  always_comb begin
    st_d    = st_q;
    tag_d   = tag_q;
    hit_d   = 1'b0;
    req_d   = 1'b0;
    racao_d = 2'b00;
    raddr_d = '0;
    wb_d    = 1'b0;
    waddr_d = '0;
    abort_d = 1'b0;

    // Snoop wins the cycle; any concurrent CPU request is stalled.
    if (snoop) begin
      if (s_match) begin
        if (st_q[s_idx] == ST_M) begin
          wb_d    = 1'b1;
          abort_d = 1'b1;
          waddr_d = bus_addr;
          st_d[s_idx] = (bus_acao == ACT_RD) ? ST_S : ST_I;
        end else if (bus_acao != ACT_RD) begin
          st_d[s_idx] = ST_I;
        end
      end
    end else if (cpu_valid) begin
      unique case (1'b1)
        c_match && !cpu_write: begin
          hit_d = 1'b1;
        end
        c_match && cpu_write: begin
          hit_d = 1'b1;
          if (st_q[c_idx] != ST_M) begin
            st_d[c_idx] = ST_M;
            req_d   = 1'b1;
            racao_d = ACT_INV;
            raddr_d = cpu_addr;
          end
        end
        !c_match: begin
          req_d   = 1'b1;
          racao_d = cpu_write ? ACT_WR : ACT_RD;
          raddr_d = cpu_addr;
          if (st_q[c_idx] == ST_M) begin
            wb_d    = 1'b1;
            waddr_d = {tag_q[c_idx], c_idx};
          end
          tag_d[c_idx] = c_tag;
          st_d[c_idx]  = cpu_write ? ST_M : ST_S;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        st_q[i]  <= ST_I;
        tag_q[i] <= '0;
      end
      hit_q   <= 1'b0;
      req_q   <= 1'b0;
      racao_q <= 2'b00;
      raddr_q <= '0;
      wb_q    <= 1'b0;
      waddr_q <= '0;
      abort_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      tag_q   <= tag_d;
      hit_q   <= hit_d;
      req_q   <= req_d;
      racao_q <= racao_d;
      raddr_q <= raddr_d;
      wb_q    <= wb_d;
      waddr_q <= waddr_d;
      abort_q <= abort_d;
    end
  end

  assign cpu_hit      = hit_q;
  assign bus_req      = req_q;
  assign bus_req_acao = racao_q;
  assign bus_req_addr = raddr_q;
  assign writeback    = wb_q;
  assign wb_addr      = waddr_q;
  assign abort        = abort_q;

`ifdef WB_COUNT_EN
  logic [15:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    wb_cnt_d = wb_cnt_q;
    if (wb_d && (wb_cnt_q != 16'hFFFF)) begin
      wb_cnt_d = wb_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_cnt_q <= '0;
    end else begin
      wb_cnt_q <= wb_cnt_d;
    end
  end

  assign wb_count = wb_cnt_q;
`endif

endmodule
